gcd_driver: RTL and testbench
=============================

# gcd_driver

Front-end requester for the GCD engine. Accepts operand pairs from upstream over a valid/ready interface and buffers them in a small FIFO. Issues them one at a time to the engine's `ld_i`/`ready`/`done` handshake, captures each result and presents it downstream over valid/ready. Sits between the system bus adapter and the GCD controller/datapath pair.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `DEPTH`, 4: request FIFO depth in entries; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset; asynchronous, active-low.
- `req_valid_i` in 1: upstream request valid.
- `req_ready_o` out 1: FIFO can accept a request.
- `req_a_i` in WIDTH: operand A.
- `req_b_i` in WIDTH: operand B.
- `gcd_ld_o` out 1: one-cycle load pulse to the engine's `ld_i`.
- `gcd_a_o` out WIDTH: operand A to the engine; held until the next issue.
- `gcd_b_o` out WIDTH: operand B to the engine; held until the next issue.
- `gcd_ready_i` in 1: engine in READY.
- `gcd_done_i` in 1: engine in DONE (single-cycle pulse).
- `gcd_result_i` in WIDTH: engine result, valid while `gcd_done_i` is high.
- `rsp_valid_o` out 1: result available.
- `rsp_ready_i` in 1: downstream accepts result.
- `rsp_result_o` out WIDTH: result.
- `busy_o` out 1: FIFO non-empty, or FSM not IDLE, or `rsp_valid_o` high.
- `err_o` out 1: sticky; `gcd_done_i` was seen outside WAIT.

## Operation
- **FIFO**
  - Push when `req_valid_i && req_ready_o`.
  - `req_ready_o` = !full, from the registered count. When full, no push occurs even if a pop happens the same cycle.
  - Simultaneous push and pop when neither full nor empty: count unchanged.
  - Pointers wrap modulo DEPTH.
  - A pushed entry is poppable no earlier than the next cycle.
- **Response slot:** one register.
  - "Slot free" = `!rsp_valid_o || rsp_ready_i`.
  - `rsp_valid_o` clears on `rsp_valid_o && rsp_ready_i` unless a new result loads in the same cycle.
- **FSM states:** IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when FIFO non-empty, `gcd_ready_i`, and slot free.
    - Pop the FIFO head.
    - Latch the head into `gcd_a_o` and `gcd_b_o`.
  - ISSUE: `gcd_ld_o` = 1 for exactly one cycle, then → WAIT unconditionally.
  - WAIT → IDLE on `gcd_done_i`.
    - `rsp_result_o` ← `gcd_result_i`; `rsp_valid_o` ← 1.
    - The slot is guaranteed free because the issue required it.
  - Only one request is outstanding at the engine at any time.
- **Unexpected done:** `gcd_done_i` in IDLE or ISSUE is ignored for data and sets `err_o`. `err_o` is cleared only by reset.
- **Reset mid-operation**
  - All state clears immediately: FIFO emptied, FSM → IDLE.
  - Any in-flight engine result is lost. The engine is reset by the same `resetn`.
- **Reset values:**
  - `req_ready_o` = 1.
  - `gcd_ld_o`, `rsp_valid_o`, `busy_o`, `err_o` = 0.
  - `gcd_a_o`, `gcd_b_o`, `rsp_result_o` = 0.

## Timing
- Request accepted at edge N; earliest `gcd_ld_o` high in cycle N+1 (ISSUE), given engine ready and slot free.
- The engine sees `ld_i` in cycle N+1 and enters LOAD at N+2. `gcd_a_o` and `gcd_b_o` stay stable from N+1 through the engine's DONE.
- `gcd_done_i` at cycle M → `rsp_valid_o` high from M+1.
- Next issue:
  - The earliest next ISSUE is M+2, provided the engine has returned to READY and the slot is free.
  - A response drained in the same cycle as the IDLE check counts as a free slot.
- `rsp_valid_o` and `rsp_result_o` are held stable until accepted.

## Configuration
- `GCD_DRIVER_ZERO_BYPASS_EN` defined:
  - In IDLE with the slot free, a head entry with `a == 0` or `b == 0` is popped without engaging the engine (`gcd_ready_i` not required).
  - `rsp_result_o` ← `a | b`, so gcd(x,0)=x and gcd(0,0)=0. `rsp_valid_o` is high the next cycle.
  - FSM stays IDLE and `gcd_ld_o` stays 0.
- Macro undefined: zero operands are issued to the engine like any other pair, and the bypass logic is absent.

## Test plan
- **Single request:** reset, push (48,18) with engine model ready → one `gcd_ld_o` pulse with `gcd_a_o`=48 and `gcd_b_o`=18; after the model pulses done with 6, `rsp_valid_o`=1 and `rsp_result_o`=6, held while `rsp_ready_i`=0.
- **FIFO full:** push 4 pairs with `gcd_ready_i`=0 → `req_ready_o` falls after the 4th push and a 5th push is refused. Raise `gcd_ready_i` → results 6, 1, 12, 5 for (48,18), (17,5), (36,24), (25,10), returned in order.
- **Backpressure:** hold `rsp_ready_i`=0 with 2 requests queued → no second `gcd_ld_o` until the first response is accepted; accept and issue in the same cycle is allowed.
- **Spurious done:** pulse `gcd_done_i` in IDLE → `err_o`=1 and stays set; `rsp_valid_o` unaffected.
- **Reset mid-operation:** assert `resetn`=0 during WAIT with 2 queued → all outputs return to reset values asynchronously; after release the FIFO is empty and `req_ready_o`=1.
- **Zero bypass** (`GCD_DRIVER_ZERO_BYPASS_EN`): push (0,9) → `rsp_result_o`=9 one cycle after pop with no `gcd_ld_o`; push (0,0) → result 0. Without the macro, (0,9) produces a `gcd_ld_o` pulse.

Source files
------------

// File: rtl/gcd_driver.sv
// gcd_driver: FIFO-buffered requester driving the GCD engine ld/ready/done handshake.
// Optional GCD_DRIVER_ZERO_BYPASS_EN: zero-operand pairs are answered locally with a|b.
module gcd_driver #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             gcd_ld_o,
    output logic [WIDTH-1:0] gcd_a_o,
    output logic [WIDTH-1:0] gcd_b_o,
    input  logic             gcd_ready_i,
    input  logic             gcd_done_i,
    input  logic [WIDTH-1:0] gcd_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] mem_a_d [DEPTH];
    logic [WIDTH-1:0] mem_b_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d, head_a, head_b, rsp_data;
    logic             rsp_valid_q, rsp_valid_d, err_q, err_d;
    logic             full, empty, slot_free, push, pop, rsp_load, bypass;

    always_comb begin
        full      = cnt_q == (AW+1)'(DEPTH);
        empty     = cnt_q == '0;
        slot_free = !rsp_valid_q || rsp_ready_i;
        head_a    = mem_a_q[rd_ptr_q];
        head_b    = mem_b_q[rd_ptr_q];
        push      = req_valid_i && !full;
`ifdef GCD_DRIVER_ZERO_BYPASS_EN
        bypass    = head_a == '0 || head_b == '0;
`else
        bypass    = 1'b0;
`endif
        pop       = 1'b0;
        rsp_load  = 1'b0;
        state_d   = state_q;
        gcd_a_d   = gcd_a_q;
        gcd_b_d   = gcd_b_q;
        case (state_q)
            IDLE: if (!empty && slot_free) begin
                if (bypass) begin
                    pop      = 1'b1;
                    rsp_load = 1'b1;
                end else if (gcd_ready_i) begin
                    pop     = 1'b1;
                    gcd_a_d = head_a;
                    gcd_b_d = head_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (gcd_done_i) begin
                rsp_load = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_data = bypass && state_q == IDLE ? head_a | head_b : gcd_result_i;
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = req_a_i;
            mem_b_d[wr_ptr_q] = req_b_i;
        end
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        rsp_valid_d  = rsp_load || (rsp_valid_q && !rsp_ready_i);
        rsp_result_d = rsp_load ? rsp_data : rsp_result_q;
        // A done outside WAIT has no matching request; flag it and drop the data.
        err_d        = err_q || (gcd_done_i && state_q != WAIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            mem_a_q      <= '{default: '0};
            mem_b_q      <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            gcd_a_q      <= '0;
            gcd_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_a_q      <= mem_a_d;
            mem_b_q      <= mem_b_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            err_q        <= err_d;
        end
    end

    assign req_ready_o  = !full;
    assign gcd_ld_o     = state_q == ISSUE;
    assign gcd_a_o      = gcd_a_q;
    assign gcd_b_o      = gcd_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign busy_o       = !empty || state_q != IDLE || rsp_valid_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_gcd_driver.sv
// tb_gcd_driver: table-driven check of gcd_driver against a behavioural GCD engine.
module tb_gcd_driver;
    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid_i, req_ready_o;
    logic [15:0] req_a_i, req_b_i;
    logic        gcd_ld_o, gcd_ready_i, gcd_done_i;
    logic [15:0] gcd_a_o, gcd_b_o, gcd_result_i;
    logic        rsp_valid_o, rsp_ready_i, busy_o, err_o;
    logic [15:0] rsp_result_o;

    int total = 0;
    int bad   = 0;

    gcd_driver dut (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .gcd_ld_o(gcd_ld_o), .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o),
        .gcd_ready_i(gcd_ready_i), .gcd_done_i(gcd_done_i), .gcd_result_i(gcd_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: fixed latency, one-cycle done, not ready while busy or in DONE.
    logic        eng_en, eng_busy, eng_done, spur;
    logic [15:0] eng_res, eng_a, eng_b;
    int          eng_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
            eng_cnt  <= 0;
            eng_res  <= '0;
            eng_a    <= '0;
            eng_b    <= '0;
        end else begin
            eng_done <= 1'b0;
            if (gcd_ld_o && !eng_busy) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 3;
                eng_a    <= gcd_a_o;
                eng_b    <= gcd_b_o;
                eng_res  <= gcd_ref(gcd_a_o, gcd_b_o);
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    eng_done <= 1'b1;
                    eng_busy <= 1'b0;
                end else eng_cnt <= eng_cnt - 1;
            end
        end
    end
    assign gcd_ready_i  = eng_en && !eng_busy && !eng_done;
    assign gcd_done_i   = eng_done || spur;
    assign gcd_result_i = eng_done ? eng_res : 16'hdead;

    int   ld_cnt = 0;
    logic ld_prev = 1'b0, ld_double = 1'b0, opnd_moved = 1'b0;
    always @(posedge clk) begin
        ld_prev <= gcd_ld_o;
        if (gcd_ld_o) ld_cnt <= ld_cnt + 1;
        if (gcd_ld_o && ld_prev) ld_double <= 1'b1;
        if (eng_busy && (gcd_a_o != eng_a || gcd_b_o != eng_b)) opnd_moved <= 1'b1;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        req_valid_i = 1'b1;
        req_a_i     = a;
        req_b_i     = b;
        while (!req_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready_o) check("push_timeout", 0, 1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_ld(input string name, output int cyc);
        cyc = 0;
        while (!gcd_ld_o && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!gcd_ld_o) check({name, "_ld_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rsp_valid_o && n < 200) begin
            tick();
            n++;
        end
        if (!rsp_valid_o) check({name, "_rsp_timeout"}, 0, 1);
    endtask

    task automatic get_rsp(input string name, input logic [15:0] exp);
        wait_valid(name);
        check(name, rsp_result_o, exp);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, base, n;
        vt[0] = '{16'd48,  16'd18, 16'd6};
        vt[1] = '{16'd17,  16'd5,  16'd1};
        vt[2] = '{16'd36,  16'd24, 16'd12};
        vt[3] = '{16'd25,  16'd10, 16'd5};
        vt[4] = '{16'd7,   16'd7,  16'd7};
        vt[5] = '{16'd100, 16'd75, 16'd25};
        resetn = 1'b0; req_valid_i = 1'b0; req_a_i = '0; req_b_i = '0;
        rsp_ready_i = 1'b0; eng_en = 1'b0; spur = 1'b0;
        repeat (2) tick();
        check("rst_req_ready", req_ready_o, 1);
        check("rst_ld", gcd_ld_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_operands", {gcd_a_o, gcd_b_o}, 0);
        check("rst_result", rsp_result_o, 0);
        @(negedge clk) resetn = 1'b1;
        tick();

        // Single request with response held under backpressure
        eng_en = 1'b1;
        push(16'd48, 16'd18);
        wait_ld("single", cyc);
        check("single_ld_latency", cyc, 1);
        check("single_a", gcd_a_o, 48);
        check("single_b", gcd_b_o, 18);
        tick();
        check("single_ld_pulse_end", gcd_ld_o, 0);
        n = 0;
        while (!gcd_done_i && n < 200) begin
            tick();
            n++;
        end
        check("single_done_seen", gcd_done_i, 1);
        check("single_valid_before_done", rsp_valid_o, 0);
        tick();
        check("single_valid_after_done", rsp_valid_o, 1);
        check("single_result", rsp_result_o, 6);
        base = ld_cnt;
        repeat (4) tick();
        check("single_hold_valid", rsp_valid_o, 1);
        check("single_hold_result", rsp_result_o, 6);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("single_drained", rsp_valid_o, 0);
        check("single_idle_busy", busy_o, 0);
        check("single_ld_count", ld_cnt - base, 0);

        // FIFO full with engine held off, then drain in order
        eng_en = 1'b0;
        base = ld_cnt;
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", req_ready_o, 1);
            push(vt[i].a, vt[i].b);
        end
        check("full_ready_low", req_ready_o, 0);
        check("full_busy", busy_o, 1);
        req_valid_i = 1'b1; req_a_i = 16'd99; req_b_i = 16'd3;
        repeat (2) tick();
        req_valid_i = 1'b0;
        check("full_still_full", req_ready_o, 0);
        check("full_no_issue", ld_cnt - base, 0);
        eng_en = 1'b1;
        for (int i = 0; i < 4; i++) get_rsp("full_drain", vt[i].exp);
        repeat (20) tick();
        check("full_no_fifth", rsp_valid_o, 0);
        check("full_ld_count", ld_cnt - base, 4);
        check("full_idle_busy", busy_o, 0);

        // Backpressure: second issue waits for the slot, may coincide with accept
        base = ld_cnt;
        push(vt[2].a, vt[2].b);
        push(vt[3].a, vt[3].b);
        wait_valid("bp_first");
        check("bp_first_result", rsp_result_o, 12);
        repeat (10) tick();
        check("bp_one_issue", ld_cnt - base, 1);
        check("bp_held_result", rsp_result_o, 12);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("bp_issue_on_accept", gcd_ld_o, 1);
        check("bp_issue_a", gcd_a_o, 25);
        check("bp_valid_cleared", rsp_valid_o, 0);
        get_rsp("bp_second", 5);

        // Spurious done in IDLE
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_err", err_o, 1);
        check("spur_no_rsp", rsp_valid_o, 0);
        repeat (3) tick();
        check("spur_err_sticky", err_o, 1);

        // Table sweep, one request at a time
        for (int i = 0; i < 6; i++) begin
            push(vt[i].a, vt[i].b);
            wait_ld("sweep", cyc);
            check("sweep_a", gcd_a_o, vt[i].a);
            check("sweep_b", gcd_b_o, vt[i].b);
            get_rsp("sweep_result", vt[i].exp);
        end
        check("sweep_err_kept", err_o, 1);

        // Reset during WAIT with two requests queued
        push(vt[4].a, vt[4].b);
        push(vt[0].a, vt[0].b);
        push(vt[1].a, vt[1].b);
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready_o, 1);
        check("mid_rst_ld", gcd_ld_o, 0);
        check("mid_rst_rsp_valid", rsp_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_operands", {gcd_a_o, gcd_b_o}, 0);
        check("mid_rst_result", rsp_result_o, 0);
        @(negedge clk) resetn = 1'b1;
        base = ld_cnt;
        repeat (15) tick();
        check("post_rst_no_issue", ld_cnt - base, 0);
        check("post_rst_no_rsp", rsp_valid_o, 0);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_req_ready", req_ready_o, 1);

`ifdef GCD_DRIVER_ZERO_BYPASS_EN
        eng_en = 1'b0;
        base = ld_cnt;
        push(16'd0, 16'd9);
        tick();
        check("bypass_valid", rsp_valid_o, 1);
        check("bypass_result", rsp_result_o, 9);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        push(16'd0, 16'd0);
        tick();
        check("bypass_zero_valid", rsp_valid_o, 1);
        check("bypass_zero_result", rsp_result_o, 0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        check("bypass_no_ld", ld_cnt - base, 0);
        eng_en = 1'b1;
`else
        eng_en = 1'b1;
        base = ld_cnt;
        push(16'd0, 16'd9);
        wait_ld("zero", cyc);
        check("zero_a", gcd_a_o, 0);
        check("zero_b", gcd_b_o, 9);
        get_rsp("zero_result", 9);
        check("zero_ld_count", ld_cnt - base, 1);
`endif

        check("ld_single_cycle", ld_double, 0);
        check("operands_stable", opnd_moved, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
